core_seq_ctrl: RTL

//  Multi-cycle sequencer for the fetch/decode/execute/regfile datapath.
//  - Issues instruction fetches over a valid/ready request channel and waits for the response.
//  - Holds the fetched instruction stable for one EXEC cycle.
//  - Gates the regfile write, advances the PC (sequential or branch), and supports halt and fault stop.
//  - Sits between the core top level and the instruction memory; replaces the free-running PC.

---
 rtl/core_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch over a valid/ready channel, wait for the
// response, present the instruction for one EXEC cycle, then advance the PC.
// Halt stops at an instruction boundary; fetch errors, timeouts and misaligned
// branch targets park the sequencer in FAULT until reset.
module core_seq_ctrl #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req_valid,
  input  logic        fetch_req_ready,
  output logic [63:0] fetch_addr,
  input  logic        fetch_rsp_valid,
  input  logic [31:0] fetch_rsp_inst,
  input  logic        fetch_rsp_err,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        rd_w_gate,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [63:0] pc,
  output logic [63:0] instret
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StExec,
    StHalt,
    StFault
  } state_e;

  // Last counter value before a silent WAIT is declared dead (unused when TIMEOUT is 0).
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] instret_q, instret_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic        halted_q;
  logic        misaligned;
  logic        timeout_hit;

  assign misaligned  = branch_taken && (branch_target[1:0] != 2'b00);
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TimeoutLast);

  // Next-state, datapath updates and state-decoded handshake outputs.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instret_d       = instret_q;
    inst_d          = inst_q;
    wait_cnt_d      = '0;
    fetch_req_valid = 1'b0;
    inst_valid      = 1'b0;
    rd_w_gate       = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = halt_req ? StHalt : StFetch;
      end
      StFetch: begin
        fetch_req_valid = 1'b1;
        if (fetch_req_ready) state_d = StWait;
      end
      StWait: begin
        wait_cnt_d = wait_cnt_q + 32'd1;
        if (fetch_rsp_valid && !fetch_rsp_err) begin
          inst_d     = fetch_rsp_inst;
          wait_cnt_d = '0;
          state_d    = StExec;
        end else if (fetch_rsp_valid || timeout_hit) begin
          wait_cnt_d = '0;
          state_d    = StFault;
        end
      end
      StExec: begin
        inst_valid = 1'b1;
        // A misaligned target must not retire: suppress the write and freeze pc/instret.
        if (misaligned) begin
          state_d = StFault;
        end else begin
          rd_w_gate = 1'b1;
          pc_d      = branch_taken ? branch_target : pc_q + 64'd4;
          instret_d = instret_q + 64'd1;
          state_d   = halt_req ? StHalt : StFetch;
        end
      end
      StHalt: begin
        if (!halt_req) state_d = StFetch;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset wins over any in-flight handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= PC_RESET;
      instret_q  <= '0;
      inst_q     <= '0;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instret_q  <= instret_d;
      inst_q     <= inst_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= (state_d == StHalt);
    end
  end

  assign fetch_addr = pc_q;
  assign pc         = pc_q;
  assign instret    = instret_q;
  assign inst       = inst_q;
  assign halted     = halted_q;
  assign fault      = (state_q == StFault);

endmodule
